// File: rtl/spi_keys_pkg.sv
// spi_keys_pkg
//   Shared constants for the SPI key-state reader.
//   ADDR_W      : width of the key address carried in one frame
//   FRAME_BITS  : SCLK rising edges per frame
//   SYNC_STAGES : depth of every input synchronizer
//   CS_IDLE     : chip-select level while no host transaction is active
package spi_keys_pkg;

  localparam int ADDR_W      = 8;
  localparam int FRAME_BITS  = 8;
  localparam int SYNC_STAGES = 2;
  localparam int BIT_CNT_W   = $clog2(FRAME_BITS);
  localparam int ADDR_SPACE  = 1 << ADDR_W;

  localparam logic CS_IDLE = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Multi-bit chain of flops that brings asynchronous levels into the clk
//   domain. Each bit is synchronized on its own; there is no
//   cross-bit coherency guarantee.
//   Ports:
//     clk   : destination clock
//     rst_n : asynchronous active-low reset, loads RESET_VAL into every stage
//     d     : asynchronous input levels
//     q     : synchronized levels (SYNC_STAGES clk of latency)
module sync_2ff
  import spi_keys_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        stage[s] <= RESET_VAL;
      end
    end else begin
      stage[0] <= d;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        stage[s] <= stage[s-1];
      end
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/spi_keys.sv
// spi_keys
//   SPI mode-0 slave that returns the synchronized state of one key.
//   The host shifts an 8-bit key address in MSB first; on the 8th rising
//   SCLK edge of a frame the addressed key level (0 when the address is
//   beyond NUM_KEYS) is captured onto MISO and held until the next frame
//   completes or chip select rises. All SPI pins are oversampled by clk_g_i.
//   Ports:
//     clk_g_i      : system clock
//     rstn_g_i     : asynchronous active-low reset
//     spi_clk_g_i  : SCLK from host (asynchronous)
//     spi_mosi_g_i : address bits, MSB first
//     spi_miso_g_o : registered state of the addressed key
//     spi_cs_g_i   : chip select, active low
//     keys_i_g     : raw key levels, 1 = pressed (asynchronous)
module spi_keys
  import spi_keys_pkg::*;
#(
  parameter int NUM_KEYS = 89
) (
  input  logic                clk_g_i,
  input  logic                rstn_g_i,
  input  logic                spi_clk_g_i,
  input  logic                spi_mosi_g_i,
  output logic                spi_miso_g_o,
  input  logic                spi_cs_g_i,
  input  logic [NUM_KEYS-1:0] keys_i_g
);

  // The three SPI pins share one synchronizer so they stay cycle-aligned.
  logic [2:0]          spi_sync;
  logic                cs_sync;
  logic                sclk_sync;
  logic                mosi_sync;
  logic [NUM_KEYS-1:0] keys_sync;

  sync_2ff #(
    .WIDTH     (3),
    .RESET_VAL ({CS_IDLE, 1'b0, 1'b0})
  ) u_spi_sync (
    .clk   (clk_g_i),
    .rst_n (rstn_g_i),
    .d     ({spi_cs_g_i, spi_clk_g_i, spi_mosi_g_i}),
    .q     (spi_sync)
  );

  assign {cs_sync, sclk_sync, mosi_sync} = spi_sync;

  sync_2ff #(
    .WIDTH     (NUM_KEYS),
    .RESET_VAL ('0)
  ) u_key_sync (
    .clk   (clk_g_i),
    .rst_n (rstn_g_i),
    .d     (keys_i_g),
    .q     (keys_sync)
  );

  // Zero-extend the key vector to the full address space so that
  // out-of-range addresses read as 0 and the select index is exactly ADDR_W.
  logic [ADDR_SPACE-1:0] keys_pad;

  for (genvar gi = 0; gi < ADDR_SPACE; gi++) begin : g_pad
    if (gi < NUM_KEYS) begin : g_key
      assign keys_pad[gi] = keys_sync[gi];
    end else begin : g_zero
      assign keys_pad[gi] = 1'b0;
    end
  end

  logic                 sclk_prev;
  logic                 sclk_rise;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [ADDR_W-1:0]    shift;
  logic [ADDR_W-1:0]    addr;
  logic                 miso;

  assign sclk_rise = sclk_sync & ~sclk_prev;
  // Address as it stands once the current MOSI bit is included; only
  // meaningful on the frame-completing edge.
  assign addr      = {shift[ADDR_W-2:0], mosi_sync};

  always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
    if (!rstn_g_i) begin
      sclk_prev <= 1'b0;
      bit_cnt   <= '0;
      shift     <= '0;
      miso      <= 1'b0;
    end else begin
      sclk_prev <= sclk_sync;
      if (cs_sync == CS_IDLE) begin
        // Deselected: drop any partial frame and release MISO.
        bit_cnt <= '0;
        shift   <= '0;
        miso    <= 1'b0;
      end else if (sclk_rise) begin
        shift   <= addr;
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1)) begin
          // Snapshot: later key changes do not reach MISO until next frame.
          miso <= keys_pad[addr];
        end
      end
    end
  end

  assign spi_miso_g_o = miso;

endmodule

// File: tb/tb_spi_keys.sv
module tb_spi_keys;

  localparam int NK = 89;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          sclk = 1'b0;
  logic          mosi = 1'b0;
  logic          cs = 1'b1;
  logic          miso;
  logic [NK-1:0] keys = '0;

  int compared = 0;
  int mismatched = 0;

  // Reference key table covering the whole 8-bit address space.
  bit ref_keys [256];

  always #5 clk = ~clk;

  spi_keys #(.NUM_KEYS(NK)) dut (
    .clk_g_i      (clk),
    .rstn_g_i     (rstn),
    .spi_clk_g_i  (sclk),
    .spi_mosi_g_i (mosi),
    .spi_miso_g_o (miso),
    .spi_cs_g_i   (cs),
    .keys_i_g     (keys)
  );

  function automatic logic model_miso(input logic [7:0] a);
    if (int'(a) < NK) return ref_keys[a];
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_keys();
    for (int i = NK - 1; i >= 0; i--) keys = {keys[NK-2:0], logic'(ref_keys[i])};
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_ref();
    for (int i = 0; i < 256; i++) ref_keys[i] = 1'b0;
  endtask

  // Send the top n bits of b, half-period 7 clk. On the last bit, MISO is
  // sampled 4 clk after the rising edge into m.
  task automatic send_bits(input logic [7:0] b, input int n, output logic m);
    m = 1'bx;
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk) mosi = b[i];
      repeat (7) @(negedge clk);
      sclk = 1'b1;
      if (i == 8 - n) begin
        repeat (4) @(negedge clk);
        m = miso;
        repeat (3) @(negedge clk);
      end else begin
        repeat (7) @(negedge clk);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] a);
    logic m;
    send_bits(a, 8, m);
    check($sformatf("%s addr=%0d lat4", tag, a), 32'(m), 32'(model_miso(a)));
    $display("frame %s addr=0x%02h miso=%0b", tag, a, m);
  endtask

  task automatic select(input logic lvl);
    @(negedge clk) cs = lvl;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    logic m;
    logic [7:0] a;

    // Reset with CS high.
    clear_ref();
    repeat (5) @(negedge clk);
    check("rst_miso", 32'(miso), 0);
    check("rst_cnt", 32'(dut.bit_cnt), 0);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_miso", 32'(miso), 0);

    // Single read.
    ref_keys[5] = 1'b1;
    drive_keys();
    select(1'b0);
    frame("single", 8'h05);
    frame("single", 8'h04);
    // Held value after frame with a 1, then key change does not alter it.
    frame("single", 8'h05);
    ref_keys[5] = 1'b0;
    drive_keys();
    check("snapshot", 32'(miso), 1);
    select(1'b1);
    check("cs_high_miso", 32'(miso), 0);

    // Full sweep of random keys, back-to-back frames under one CS.
    for (int i = 0; i < NK; i++) ref_keys[i] = bit'($urandom_range(1, 0));
    drive_keys();
    select(1'b0);
    for (int i = 0; i < NK; i++) frame("sweep", 8'(i));
    // Random addresses, both in and out of range.
    for (int i = 0; i < 12; i++) begin
      a = 8'($urandom_range(255, 0));
      frame("rand", a);
    end
    select(1'b1);

    // Out of range with every key pressed.
    for (int i = 0; i < 256; i++) ref_keys[i] = 1'b1;
    drive_keys();
    select(1'b0);
    frame("oor", 8'h59);
    frame("oor", 8'hFF);
    frame("oor", 8'h58);

    // CS abort mid-frame.
    clear_ref();
    ref_keys[3] = 1'b1;
    ref_keys[0] = 1'b1;
    drive_keys();
    frame("pre_abort", 8'h00);
    send_bits(8'h80, 4, m);
    select(1'b1);
    check("abort_miso", 32'(miso), 0);
    select(1'b0);
    frame("after_abort", 8'h03);

    // Reset mid-frame.
    clear_ref();
    ref_keys[1] = 1'b1;
    ref_keys[3] = 1'b1;
    drive_keys();
    frame("pre_rst", 8'h03);
    send_bits(8'h01, 5, m);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 check("rst_mid_miso", 32'(miso), 0);
    check("rst_mid_cnt", 32'(dut.bit_cnt), 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    drive_keys();
    repeat (4) @(negedge clk);
    frame("after_rst", 8'h01);
    frame("after_rst", 8'h02);
    select(1'b1);
    check("final_idle", 32'(miso), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout compared=%0d required=finish", compared);
    $fatal(1, "timeout");
  end

endmodule
